// File: rtl/data_acquisition_ip_if.sv
// data_acquisition_ip_if: CPU command, sensor readings and result word.
// master drives command/readings, slave returns the result.
interface data_acquisition_ip_if;
  logic [31:0]      cpu_command;
  logic [7:0][15:0] sensor_readings;
  logic [31:0]      result_for_cpu;

  modport master (
    output cpu_command,
    output sensor_readings,
    input  result_for_cpu
  );

  modport slave (
    input  cpu_command,
    input  sensor_readings,
    output result_for_cpu
  );
endinterface

// File: rtl/data_acquisition_ip.sv
// data_acquisition_ip: command-driven sensor sequencer with result store.
// Define DAQ_SILC_TIMEOUT_EN to enable the SILC measurement timeout.
module data_acquisition_ip (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  data_acquisition_ip_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DONE,
    ERROR
  } state_t;

  localparam logic [1:0] M_CLR  = 2'b00;
  localparam logic [1:0] M_SLOW = 2'b10;
  localparam logic [1:0] M_FAST = 2'b01;
  localparam logic [1:0] M_BAD  = 2'b11;

  localparam logic [2:0] S_NONE = 3'd0;
  localparam logic [2:0] S_ROSC = 3'd1;
  localparam logic [2:0] S_DC   = 3'd2;
  localparam logic [2:0] S_EM   = 3'd3;
  localparam logic [2:0] S_TDDB = 3'd4;
  localparam logic [2:0] S_SILC = 3'd5;
  localparam logic [2:0] S_TEMP = 3'd6;
  localparam logic [2:0] S_VOLT = 3'd7;

  localparam logic [11:0] HI_LVL = 12'd3000;
  localparam logic [11:0] LO_LVL = 12'd1000;

  state_t      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] res_q, res_d;
  logic [23:0] cnt_q, cnt_d;
  logic [11:0] cyc_q, cyc_d;
  logic [23:0] len_q, len_d;
  logic [5:0]  nsl_q, nsl_d;
  logic        in_sl_q, in_sl_d;
  logic        prev_q;
  logic [23:0] stored_q [1:7];

  logic [31:0] cmd;
  logic [2:0]  sns_in;
  logic [2:0]  sns_q;
  logic [6:0]  win_q;
  logic [5:0]  slp_q;
  logic [11:0] tmo_q;
  logic        is_cnt;
  logic        is_snap;
  logic        is_silc;
  logic        inc;
  logic [11:0] silc;
  logic        hi;
  logic        lo;
  logic [23:0] snap;
  logic [23:0] rd_store;
  logic        fin;
  logic        fin_to;
  logic [23:0] fin_data;
  logic        clr;
  logic        unused_bits;

  assign cmd    = bus.cpu_command;
  assign sns_in = cmd[29:27];
  assign sns_q  = cmd_q[29:27];
  assign win_q  = cmd_q[26:20];
  assign slp_q  = cmd_q[19:14];
  assign tmo_q  = cmd_q[13:2];

  assign is_cnt  = (sns_q == S_ROSC) || (sns_q == S_TDDB);
  assign is_silc = (sns_q == S_SILC);
  assign is_snap = (sns_q == S_DC) || (sns_q == S_EM) ||
                   (sns_q == S_TEMP) || (sns_q == S_VOLT);

  assign inc = (sns_q == S_ROSC)
             ? (bus.sensor_readings[1][0] & ~prev_q)
             : bus.sensor_readings[4][0];

  assign silc = bus.sensor_readings[5][11:0];
  assign hi   = (silc >= HI_LVL);
  assign lo   = (silc <= LO_LVL);

  assign bus.result_for_cpu = res_q;

  assign unused_bits = ^{cmd[1:0], cmd_q[1:0], tmo_q,
                         bus.sensor_readings[0],
                         bus.sensor_readings[1][15:1],
                         bus.sensor_readings[2][15:12],
                         bus.sensor_readings[3][15:8],
                         bus.sensor_readings[4][15:1],
                         bus.sensor_readings[5][15:12],
                         bus.sensor_readings[6][15:12],
                         bus.sensor_readings[7][15:12]};

  function automatic logic bad_cmd(input logic [31:0] c);
    logic [2:0] s;
    logic       b;
    s = c[29:27];
    b = (c[31:30] == M_BAD) || (s == S_NONE);
    if ((s == S_ROSC || s == S_TDDB) && c[26:20] == 7'd0)
      b = 1'b1;
    if (s == S_SILC && c[19:14] == 6'd0)
      b = 1'b1;
`ifdef DAQ_SILC_TIMEOUT_EN
    if (s == S_SILC && c[13:2] == 12'd0)
      b = 1'b1;
`endif
    return b;
  endfunction

  function automatic logic [23:0] sat_add(
    input logic [23:0] a,
    input logic        b
  );
    return (a == '1) ? a : a + {23'd0, b};
  endfunction

  // Masked snapshot of the selected single-shot sensor.
  always_comb begin
    snap = '0;
    unique case (sns_q)
      S_DC:    snap = {12'd0, bus.sensor_readings[2][11:0]};
      S_EM:    snap = {16'd0, bus.sensor_readings[3][7:0]};
      S_TEMP:  snap = {12'd0, bus.sensor_readings[6][11:0]};
      S_VOLT:  snap = {12'd0, bus.sensor_readings[7][11:0]};
      default: snap = '0;
    endcase
  end

  // Stored result of the sensor named by the incoming command.
  always_comb begin
    rd_store = '0;
    for (int k = 1; k < 8; k++)
      if (sns_in == 3'(k))
        rd_store = stored_q[k];
  end

  // Next state, result word and measurement counters.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    len_d    = len_q;
    nsl_d    = nsl_q;
    in_sl_d  = in_sl_q;
    fin      = 1'b0;
    fin_to   = 1'b0;
    fin_data = '0;
    clr      = 1'b0;
    if (!en) begin
      state_d = IDLE;
      res_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          res_d = '0;
          clr   = 1'b1;
          if (cmd != '0) begin
            cmd_d = cmd;
            if (cmd[31:30] == M_CLR) begin
              state_d = IDLE;
            end else if (bad_cmd(cmd)) begin
              state_d = ERROR;
              res_d   = {3'b010, sns_in, 26'd0};
            end else if (cmd[31:30] == M_FAST) begin
              state_d = DONE;
              res_d   = {3'b100, sns_in, 2'b00, rd_store};
            end else if (cmd[31:30] == M_SLOW) begin
              state_d = MEASURE;
            end
          end
        end
        MEASURE: begin
          if (cmd != cmd_q) begin
            state_d = IDLE;
            res_d   = '0;
            clr     = 1'b1;
          end else begin
            cyc_d = cyc_q + 12'd1;
            unique case (1'b1)
              is_cnt: begin
                cnt_d = sat_add(cnt_q, inc);
                if (cyc_d == {5'd0, win_q}) begin
                  fin      = 1'b1;
                  fin_data = cnt_d;
                end
              end
              is_snap: begin
                fin      = 1'b1;
                fin_data = snap;
              end
              is_silc: begin
                if (!in_sl_q) begin
                  if (hi) begin
                    in_sl_d = 1'b1;
                    len_d   = 24'd1;
                  end
                end else if (lo) begin
                  cnt_d   = cnt_q + len_q;
                  in_sl_d = 1'b0;
                  nsl_d   = nsl_q + 6'd1;
                  if (nsl_d == slp_q) begin
                    fin      = 1'b1;
                    fin_data = cnt_d;
                  end
                end else begin
                  len_d = len_q + 24'd1;
                end
`ifdef DAQ_SILC_TIMEOUT_EN
                if (!fin && cyc_d == tmo_q) begin
                  fin      = 1'b1;
                  fin_to   = 1'b1;
                  fin_data = cnt_d;
                end
`endif
              end
              default: fin = 1'b0;
            endcase
            if (fin) begin
              state_d = DONE;
              res_d   = {2'b10, fin_to, sns_q, 2'b00, fin_data};
            end
          end
        end
        DONE, ERROR: begin
          if (cmd != cmd_q) begin
            state_d = IDLE;
            res_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr) begin
      cnt_d   = '0;
      cyc_d   = '0;
      len_d   = '0;
      nsl_d   = '0;
      in_sl_d = 1'b0;
    end
  end

  // Control, result and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      len_q   <= '0;
      nsl_q   <= '0;
      in_sl_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      len_q   <= len_d;
      nsl_q   <= nsl_d;
      in_sl_q <= in_sl_d;
      prev_q  <= bus.sensor_readings[1][0];
    end
  end

  // Per-sensor result store, written when a measurement finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < 8; k++)
        stored_q[k] <= '0;
    end else if (fin) begin
      for (int k = 1; k < 8; k++)
        if (sns_q == 3'(k))
          stored_q[k] <= fin_data;
    end
  end

endmodule

// File: tb/tb_data_acquisition_ip.sv
// tb_data_acquisition_ip: random and directed checks of data_acquisition_ip
// against a behavioural model of the measurement rules.
module tb_data_acquisition_ip;
  localparam int LIM = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [23:0] stored [1:7];
  logic [15:0] smp [LIM];
  logic [15:0] pre;

  data_acquisition_ip_if bus();

  data_acquisition_ip dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [1:0]  m,
    input logic [2:0]  s,
    input logic [6:0]  n,
    input logic [5:0]  sl,
    input logic [11:0] t
  );
    return {m, s, n, sl, t, 2'b00};
  endfunction

  function automatic logic [31:0] dw(
    input logic        to,
    input logic [2:0]  s,
    input logic [23:0] d
  );
    return {1'b1, 1'b0, to, s, 2'b00, d};
  endfunction

  task automatic put(input int k, input logic [15:0] v);
    for (int j = 0; j < 8; j++)
      bus.sensor_readings[j] = 16'($urandom);
    bus.sensor_readings[k] = v;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.cpu_command = '0;
    @(negedge clk);
    chk("idle", bus.result_for_cpu, '0);
  endtask

  task automatic fast(input int s);
    @(negedge clk);
    bus.cpu_command = mk(2'b01, 3'(s), 7'd1, 6'd1, 12'd1);
    @(negedge clk);
    chk("fast", bus.result_for_cpu, dw(1'b0, 3'(s), stored[s]));
    go_idle();
  endtask

  task automatic bad(input logic [31:0] c);
    logic [31:0] w;
    w = {3'b010, c[29:27], 26'd0};
    @(negedge clk);
    bus.cpu_command = c;
    @(negedge clk);
    chk("err", bus.result_for_cpu, w);
    @(negedge clk);
    chk("err_hold", bus.result_for_cpu, w);
    go_idle();
  endtask

  // Expected finish cycle and data from the sample table.
  task automatic model(
    input  logic [31:0] c,
    output int          f,
    output logic [23:0] d
  );
    int s;
    int n;
    int sl;
    int acc;
    int cnt;
    int i;
    int a;
    logic p;
    s   = int'(c[29:27]);
    n   = int'(c[26:20]);
    sl  = int'(c[19:14]);
    f   = -1;
    acc = 0;
    case (s)
      1: begin
        for (int k = 0; k < n; k++) begin
          p = (k == 0) ? pre[0] : smp[k-1][0];
          if (smp[k][0] && !p) acc++;
        end
        f = n - 1;
      end
      4: begin
        for (int k = 0; k < n; k++)
          if (smp[k][0]) acc++;
        f = n - 1;
      end
      3: begin
        acc = int'(smp[0][7:0]);
        f = 0;
      end
      5: begin
        cnt = 0;
        i = 0;
        while (cnt < sl && i < LIM) begin
          while (i < LIM && smp[i][11:0] < 12'd3000) i++;
          a = i;
          i++;
          while (i < LIM && smp[i][11:0] > 12'd1000) i++;
          if (i < LIM) begin
            acc += i - a;
            cnt++;
            if (cnt == sl) f = i;
            i++;
          end
        end
      end
      default: begin
        acc = int'(smp[0][11:0]);
        f = 0;
      end
    endcase
    d = 24'(acc);
  endtask

  task automatic run_slow(input logic [31:0] c, input string tag);
    int          f;
    int          at;
    int          s;
    logic [23:0] d;
    s  = int'(c[29:27]);
    at = -1;
    model(c, f, d);
    @(negedge clk);
    bus.cpu_command = c;
    put(s, pre);
    for (int i = 0; i <= LIM && at < 0; i++) begin
      @(negedge clk);
      if (bus.result_for_cpu[31]) at = i - 1;
      else if (i < LIM) put(s, smp[i]);
    end
    chk({tag, "_lat"}, 32'(at), 32'(f));
    chk({tag, "_res"}, bus.result_for_cpu, dw(1'b0, 3'(s), d));
    stored[s] = d;
  endtask

  task automatic fill(input int s);
    int r;
    pre = 16'($urandom);
    for (int i = 0; i < LIM; i++) begin
      if (s == 5) begin
        r = $urandom_range(2, 0);
        if (r == 0)
          smp[i] = {4'($urandom), 12'($urandom_range(4095, 3000))};
        else if (r == 1)
          smp[i] = {4'($urandom), 12'($urandom_range(2999, 1001))};
        else
          smp[i] = {4'($urandom), 12'($urandom_range(1000, 0))};
      end else begin
        smp[i] = 16'($urandom);
      end
    end
  endtask

  initial begin
    int          s;
    logic [31:0] c;
    bus.cpu_command     = '0;
    bus.sensor_readings = '0;
    for (int k = 1; k < 8; k++) stored[k] = '0;
    #12;
    chk("rst_out", bus.result_for_cpu, '0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    fast(6);
    fast(3);

    pre = 16'd0;
    for (int i = 0; i < LIM; i++) smp[i] = 16'(i % 2 == 0);
    run_slow(32'h88400000, "rosc");
    chk("rosc_word", bus.result_for_cpu, 32'h84000002);
    go_idle();

    for (int i = 0; i < LIM; i++) smp[i] = '0;
    smp[0] = 16'd3480;
    smp[1] = 16'd2661;
    smp[2] = 16'd1600;
    smp[3] = 16'd800;
    run_slow(32'hA8007FFC, "silc");
    chk("silc_word", bus.result_for_cpu, 32'h94000003);
    go_idle();

    @(negedge clk);
    bus.cpu_command = 32'h68007FFC;
    @(negedge clk);
    chk("fast_silc", bus.result_for_cpu, 32'h94000003);
    go_idle();

    @(negedge clk);
    bus.cpu_command = mk(2'b10, 3'd1, 7'd100, 6'd0, 12'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) chk("meas_zero", bus.result_for_cpu, '0);
      put(1, 16'(i % 2));
    end
    @(negedge clk);
    bus.cpu_command = '0;
    @(negedge clk);
    chk("abort", bus.result_for_cpu, '0);
    fast(1);

    bad(32'hC8100000);
    bad(32'h80000000);
    bad(mk(2'b10, 3'd4, 7'd0, 6'd2, 12'd9));
    bad(mk(2'b01, 3'd5, 7'd3, 6'd0, 12'd5));

    @(negedge clk);
    bus.cpu_command = 32'hC8100000;
    @(negedge clk);
    chk("err_pre", bus.result_for_cpu, 32'h44000000);
    bus.cpu_command = mk(2'b01, 3'd7, 7'd1, 6'd1, 12'd1);
    @(negedge clk);
    chk("relaunch_idle", bus.result_for_cpu, '0);
    @(negedge clk);
    chk("relaunch", bus.result_for_cpu, dw(1'b0, 3'd7, stored[7]));
    go_idle();

    @(negedge clk);
    bus.cpu_command = 32'h68007FFC;
    @(negedge clk);
    chk("en_pre", bus.result_for_cpu, dw(1'b0, 3'd5, stored[5]));
    en = 1'b0;
    @(negedge clk);
    chk("en_off", bus.result_for_cpu, '0);
    en = 1'b1;
    @(negedge clk);
    chk("en_keep", bus.result_for_cpu, dw(1'b0, 3'd5, stored[5]));
    go_idle();

`ifdef DAQ_SILC_TIMEOUT_EN
    @(negedge clk);
    bus.cpu_command = mk(2'b10, 3'd5, 7'd0, 6'd1, 12'd1);
    put(5, 16'd0);
    @(negedge clk);
    put(5, 16'd0);
    @(negedge clk);
    chk("silc_tmo", bus.result_for_cpu, 32'hB4000000);
    stored[5] = '0;
    go_idle();
`endif

    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(7, 1);
      c = mk(2'b10, 3'(s), 7'($urandom_range(40, 1)),
             6'($urandom_range(3, 1)), 12'd4095);
      fill(s);
      run_slow(c, "rand");
      go_idle();
      fast($urandom_range(7, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
